// File: rtl/pll_lock_sequencer_if.sv
// rtl/pll_lock_sequencer_if.sv - control/status bundle between the PLL lock sequencer and its surroundings
// master drives the PLL lock indication and retry request; slave is the sequencer.
interface pll_lock_sequencer_if;
   logic       pll_locked;
   logic       retry_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       lock_fail;
   logic [3:0] retry_cnt;
   logic [7:0] loss_cnt;
   logic [2:0] state_o;

   modport master (
      output pll_locked,
      output retry_req,
      input  pll_rst,
      input  sys_rst,
      input  ready,
      input  lock_fail,
      input  retry_cnt,
      input  loss_cnt,
      input  state_o
   );

   modport slave (
      input  pll_locked,
      input  retry_req,
      output pll_rst,
      output sys_rst,
      output ready,
      output lock_fail,
      output retry_cnt,
      output loss_cnt,
      output state_o
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock bring-up sequencer with timeout retries and lock-loss recovery
// Moore FSM over a synchronized lock; one shared saturating cycle counter serves every timed state.
module pll_lock_sequencer #(
   parameter int RST_HOLD_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 3
) (
   input logic                  refclk,
   input logic                  rst,
   pll_lock_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      ST_PLL_RESET = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   localparam int CNT_MAX_A = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
   localparam int CW        = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] RST_LAST     = CW'(RST_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_SAT      = CW'(CNT_MAX);
   localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

   logic          sync1_q;
   logic          sync2_q;
   logic          lock_s;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]    retry_q, retry_d;
   logic [7:0]    loss_q, loss_d;

   assign lock_s  = sync2_q;
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CW'(1);

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= ST_PLL_RESET;
         cnt_q   <= '0;
         retry_q <= '0;
         loss_q  <= '0;
      end else begin
         sync1_q <= bus.pll_locked;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         loss_q  <= loss_d;
      end
   end

   // Every branch that changes state also clears the counter.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_inc;
      retry_d = retry_q;
      loss_d  = loss_q;
      case (state_q)
         ST_PLL_RESET: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TIMEOUT_LAST) begin
               cnt_d = '0;
               if (retry_q == RETRY_LIMIT) begin
                  state_d = ST_FAIL;
               end else begin
                  state_d = ST_PLL_RESET;
                  retry_d = retry_q + 4'd1;
               end
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d = ST_PLL_RESET;
               cnt_d   = '0;
               loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
            end
         end
         ST_FAIL: begin
            if (bus.retry_req) begin
               state_d = ST_PLL_RESET;
               cnt_d   = '0;
               retry_d = '0;
            end
         end
         default: begin
            state_d = ST_PLL_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      bus.pll_rst   = 1'b1;
      bus.sys_rst   = 1'b1;
      bus.ready     = 1'b0;
      bus.lock_fail = 1'b0;
      case (state_q)
         ST_WAIT_LOCK,
         ST_STABLE: bus.pll_rst = 1'b0;
         ST_RUN: begin
            bus.pll_rst = 1'b0;
            bus.sys_rst = 1'b0;
            bus.ready   = 1'b1;
         end
         ST_FAIL: bus.lock_fail = 1'b1;
         default: ;
      endcase
   end

   assign bus.retry_cnt = retry_q;
   assign bus.loss_cnt  = loss_q;
   assign bus.state_o   = state_q;

endmodule
